risc16_cpu: RTL and testbench

RISC16_CPU -- requirements
Module: risc16_cpu

---
 rtl/risc16_cpu.sv | 154 +++++++++++++++
 tb/tb_risc16_cpu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/risc16_cpu.sv
// risc16_cpu: multi-cycle 16-bit CPU (FETCH -> EXEC [-> MEM]) with a 16-entry
// register file and a single combinational-read external memory port.
// Optional build macro: R0_HARDWIRED_EN -- when defined, R0 reads as zero and
// writes to it are dropped; otherwise R0 is a normal register.
module risc16_cpu #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        halted,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_wdata,
  output logic        mem_we
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [3:0] OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2,
                         OP_AND  = 4'h3, OP_OR  = 4'h4, OP_XOR = 4'h5,
                         OP_SHL  = 4'h6, OP_SHR = 4'h7, OP_LDI = 4'h8,
                         OP_LD   = 4'h9, OP_ST  = 4'hA, OP_BEQ = 4'hB,
                         OP_JMP  = 4'hC, OP_ADDI = 4'hD, OP_HALT = 4'hF;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        halted_q, halted_d;
  logic [15:0] regfile [0:15];

  logic        rf_we;
  logic [15:0] rf_wdata;

  // instruction fields
  logic [3:0]  op, rd, rs, rt;
  logic [15:0] imm4_sx, imm8_sx, imm8_zx, imm12_zx;
  assign op       = ir_q[15:12];
  assign rd       = ir_q[11:8];
  assign rs       = ir_q[7:4];
  assign rt       = ir_q[3:0];
  assign imm4_sx  = {{12{ir_q[3]}}, ir_q[3:0]};
  assign imm8_sx  = {{8{ir_q[7]}}, ir_q[7:0]};
  assign imm8_zx  = {8'h00, ir_q[7:0]};
  assign imm12_zx = {4'h0, ir_q[11:0]};

  // register read ports
  logic [15:0] rd_val, rs_val, rt_val;
`ifdef R0_HARDWIRED_EN
  assign rd_val = (rd == 4'h0) ? 16'h0000 : regfile[rd];
  assign rs_val = (rs == 4'h0) ? 16'h0000 : regfile[rs];
  assign rt_val = (rt == 4'h0) ? 16'h0000 : regfile[rt];
`else
  assign rd_val = regfile[rd];
  assign rs_val = regfile[rs];
  assign rt_val = regfile[rt];
`endif

  // effective address for LD/ST; wraps naturally at 16 bits
  logic [15:0] ea;
  assign ea = rs_val + imm4_sx;

  // memory port: MEM state addresses data, every other state addresses PC
  assign mem_addr  = (state_q == S_MEM) ? ea : pc_q;
  assign mem_we    = (state_q == S_MEM) && (op == OP_ST);
  assign mem_wdata = mem_we ? rd_val : 16'h0000;
  assign halted    = halted_q;

  // ALU result for register-writing EXEC instructions
  logic [15:0] alu_res;
  always_comb begin
    alu_res = 16'h0000;
    case (op)
      OP_ADD:  alu_res = rs_val + rt_val;
      OP_SUB:  alu_res = rs_val - rt_val;
      OP_AND:  alu_res = rs_val & rt_val;
      OP_OR:   alu_res = rs_val | rt_val;
      OP_XOR:  alu_res = rs_val ^ rt_val;
      OP_SHL:  alu_res = rs_val << rt_val[3:0];
      OP_SHR:  alu_res = rs_val >> rt_val[3:0];
      OP_LDI:  alu_res = imm8_zx;
      OP_ADDI: alu_res = rd_val + imm8_sx;
      default: alu_res = 16'h0000;
    endcase
  end

  // next-state, PC/IR update and register write selection
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    case (state_q)
      S_FETCH: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 16'h0001;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
          OP_SHL, OP_SHR, OP_LDI, OP_ADDI: rf_we = 1'b1;
          OP_LD, OP_ST: state_d = S_MEM;
          OP_BEQ: if (rd_val == rs_val) pc_d = pc_q + imm4_sx;
          OP_JMP: pc_d = imm12_zx;
          OP_HALT: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          default: ;  // NOP and reserved opcode
        endcase
      end
      S_MEM: begin
        state_d = S_FETCH;
        if (op == OP_LD) begin
          rf_we    = 1'b1;
          rf_wdata = mem_rdata;
        end
      end
      S_HALT: ;  // terminal until reset
      default: state_d = S_FETCH;
    endcase
`ifdef R0_HARDWIRED_EN
    if (rd == 4'h0) rf_we = 1'b0;
`endif
  end

  // control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  // register file write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regfile[i] <= 16'h0000;
    end else if (rf_we) begin
      regfile[rd] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_risc16_cpu.sv
// Bench for risc16_cpu: directed programs in a small memory model; expected
// results are queued per program and checked by a separate monitor when the
// CPU halts or when the stimulus asks for a snapshot.
module tb_risc16_cpu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halted;
  logic [15:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_we;

  risc16_cpu #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .halted(halted), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  localparam int K_REG = 0, K_MEM = 1, K_PC = 2, K_HLT = 3, K_CYC = 4,
                 K_WECNT = 5, K_WE = 6, K_WDATA = 7, K_IR = 8;

  typedef struct {
    int          kind;
    int          idx;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem [0:255];
  int          we_cnt = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          done = 0;
  bit          snap_req = 0;
  bit          halted_prev = 0;
  event        snap_ev;

  assign mem_rdata = mem[mem_addr[7:0]];

  // memory write port and write-strobe counter
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:0]] = mem_wdata;
      we_cnt = we_cnt + 1;
    end
  end

  // cycles since reset release
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // monitor: drain expectations when halted rises or a snapshot is requested
  initial begin
    forever begin
      @(negedge clk or snap_ev);
      if (snap_req || (halted && !halted_prev)) begin
        while (exp_q.size() > 0) begin
          exp_t e;
          logic [15:0] act;
          e = exp_q.pop_front();
          case (e.kind)
            K_REG:   act = dut.regfile[e.idx];
            K_MEM:   act = mem[e.idx];
            K_PC:    act = dut.pc_q;
            K_HLT:   act = {15'h0, halted};
            K_CYC:   act = cyc[15:0];
            K_WECNT: act = we_cnt[15:0];
            K_WE:    act = {15'h0, mem_we};
            K_WDATA: act = mem_wdata;
            K_IR:    act = dut.ir_q;
            default: act = 16'hxxxx;
          endcase
          checks++;
          if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
          end
        end
        snap_req = 0;
        done = 1;
      end
      halted_prev = halted;
    end
  end

  task automatic expect_(input int kind, input int idx, input logic [15:0] v, input string name);
    exp_t e;
    e.kind = kind; e.idx = idx; e.exp = v; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic timeout(input string name);
    errors++;
    checks++;
    $display("FAIL %s: timed out waiting for monitor, expected completion", name);
    exp_q.delete();
  endtask

  // hold reset and clear memory for the next program
  task automatic prep();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    we_cnt = 0;
    done = 0;
  endtask

  // release reset and wait (bounded) for the monitor to see halted
  task automatic go(input int budget, input string name);
    done = 0;
    rst = 1'b0;
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    #1;
    if (!done) timeout(name);
  endtask

  task automatic snap(input string name);
    #1;
    done = 0;
    snap_req = 1;
    -> snap_ev;
    for (int i = 0; i < 5 && !done; i++) #1;
    if (!done) timeout(name);
  endtask

  initial begin
    // reset state
    prep();
    @(posedge clk); @(negedge clk);
    expect_(K_PC, 0, 16'h0000, "rst_pc");
    expect_(K_IR, 0, 16'h0000, "rst_ir");
    expect_(K_HLT, 0, 16'h0000, "rst_halted");
    expect_(K_WE, 0, 16'h0000, "rst_we");
    expect_(K_WDATA, 0, 16'h0000, "rst_wdata");
    expect_(K_REG, 5, 16'h0000, "rst_r5");
    snap("reset");

    // LDI/LDI/ADD/HALT
    prep();
    mem[0] = 16'h8105; mem[1] = 16'h8203; mem[2] = 16'h1312; mem[3] = 16'hF000;
    expect_(K_CYC, 0, 16'd8, "p1_cycles");
    expect_(K_REG, 3, 16'h0008, "p1_r3");
    expect_(K_REG, 1, 16'h0005, "p1_r1");
    go(100, "p1");

    // ST then LD through memory
    prep();
    mem[0] = 16'h8110; mem[1] = 16'h82AB; mem[2] = 16'hA210; mem[3] = 16'h9410;
    mem[4] = 16'hF000;
    expect_(K_CYC, 0, 16'd12, "p2_cycles");
    expect_(K_MEM, 16, 16'h00AB, "p2_mem10");
    expect_(K_REG, 4, 16'h00AB, "p2_r4");
    expect_(K_WECNT, 0, 16'd1, "p2_we_count");
    go(100, "p2");

    // SUB wrap and logical SHR
    prep();
    mem[0] = 16'h8101; mem[1] = 16'h2201; mem[2] = 16'h7321; mem[3] = 16'hF000;
    expect_(K_REG, 2, 16'hFFFF, "p3_r2_wrap");
    expect_(K_REG, 3, 16'h7FFF, "p3_r3_shr");
    go(100, "p3");

    // taken BEQ skips LDI, JMP to HALT at 0x020
    prep();
    mem[0] = 16'hB001; mem[1] = 16'h8509; mem[2] = 16'hC020; mem[32] = 16'hF000;
    expect_(K_CYC, 0, 16'd6, "p4_cycles");
    expect_(K_REG, 5, 16'h0000, "p4_r5_skipped");
    expect_(K_PC, 0, 16'h0021, "p4_pc");
    expect_(K_HLT, 0, 16'h0001, "p4_halted");
    go(100, "p4");

    // R0 behaviour depends on build macro
    prep();
    mem[0] = 16'h8007; mem[1] = 16'h1100; mem[2] = 16'hF000;
`ifdef R0_HARDWIRED_EN
    expect_(K_REG, 1, 16'h0000, "p5_r1_r0hw");
`else
    expect_(K_REG, 1, 16'h000E, "p5_r1_r0gpr");
`endif
    go(100, "p5");

    // ADDI, logic ops, SHL, negative LD offset, untaken BEQ, NOP, reserved
    prep();
    mem[0]  = 16'h81F0; mem[1]  = 16'hD1F0; mem[2]  = 16'h820F; mem[3]  = 16'h4312;
    mem[4]  = 16'h3432; mem[5]  = 16'h5532; mem[6]  = 16'h8604; mem[7]  = 16'h6726;
    mem[8]  = 16'hD8FF; mem[9]  = 16'h996F; mem[10] = 16'hB121; mem[11] = 16'h0000;
    mem[12] = 16'hE123; mem[13] = 16'hF000;
    expect_(K_CYC, 0, 16'd29, "p6_cycles");
    expect_(K_REG, 1, 16'h00E0, "p6_addi_neg");
    expect_(K_REG, 3, 16'h00EF, "p6_or");
    expect_(K_REG, 4, 16'h000F, "p6_and");
    expect_(K_REG, 5, 16'h00E0, "p6_xor");
    expect_(K_REG, 7, 16'h00F0, "p6_shl");
    expect_(K_REG, 8, 16'hFFFF, "p6_addi_wrap");
    expect_(K_REG, 9, 16'h4312, "p6_ld_negoff");
    expect_(K_PC, 0, 16'h000E, "p6_pc");
    expect_(K_WECNT, 0, 16'd0, "p6_no_writes");
    go(200, "p6");

    // reset during MEM of a ST aborts it
    prep();
    mem[0] = 16'h8110; mem[1] = 16'h82AB; mem[2] = 16'hA210; mem[3] = 16'hF000;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    expect_(K_WE, 0, 16'h0001, "p7_we_in_mem");
    expect_(K_WDATA, 0, 16'h00AB, "p7_wdata_in_mem");
    snap("p7a");
    rst = 1'b1;
    expect_(K_WE, 0, 16'h0000, "p7_we_async_drop");
    expect_(K_WDATA, 0, 16'h0000, "p7_wdata_drop");
    snap("p7b");
    @(posedge clk); @(negedge clk);
    expect_(K_MEM, 16, 16'h0000, "p7_mem_unchanged");
    expect_(K_PC, 0, 16'h0000, "p7_pc");
    expect_(K_REG, 1, 16'h0000, "p7_r1");
    expect_(K_REG, 2, 16'h0000, "p7_r2");
    expect_(K_HLT, 0, 16'h0000, "p7_halted");
    expect_(K_WECNT, 0, 16'd0, "p7_we_count");
    snap("p7c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
